// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: combinational hits, whole-line refill over req/ack.
// Optional hit/miss counters are built in when ICACHE_PERF_EN is defined.
module inst_cache #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_inst_o,
  output logic        cpu_stall_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int unsigned W     = $clog2(LINE_WORDS);
  localparam int unsigned L     = $clog2(NUM_LINES);
  localparam int unsigned TagW  = 30 - W - L;
  localparam int unsigned LineW = 30 - W;

  typedef enum logic [0:0] {StIdle, StRefill} state_e;

  state_e                 state_q, state_d;
  logic [W-1:0]           k_q, k_d;
  logic [LineW-1:0]       line_q, line_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [TagW-1:0]        tag_q  [NUM_LINES];
  logic [31:0]            data_q [NUM_LINES][LINE_WORDS];

  logic [W-1:0]    off;
  logic [L-1:0]    idx;
  logic [TagW-1:0] tag;
  logic [L-1:0]    ridx;
  logic [TagW-1:0] rtag;
  logic            hit, miss, ack, last;

  assign off  = cpu_addr_i[2+W-1:2];
  assign idx  = cpu_addr_i[2+W+L-1:2+W];
  assign tag  = cpu_addr_i[31:2+W+L];
  assign ridx = line_q[L-1:0];
  assign rtag = line_q[LineW-1:L];

  assign hit  = (state_q == StIdle) && cpu_ce_i && valid_q[idx] && (tag_q[idx] == tag);
  assign miss = (state_q == StIdle) && cpu_ce_i && !hit;
  assign ack  = (state_q == StRefill) && mem_ack_i;
  assign last = &k_q;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    line_d       = line_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    case (state_q)
      StIdle: begin
        if (flush_i) valid_d = '0;
        if (miss) begin
          state_d = StRefill;
          line_d  = cpu_addr_i[31:2+W];
          k_d     = '0;
        end
      end
      StRefill: begin
        if (flush_i) flush_pend_d = 1'b1;
        if (mem_ack_i) begin
          k_d = k_q + 1'b1;
          if (last) begin
            state_d       = StIdle;
            valid_d[ridx] = 1'b1;
            // A flush seen at any point of the refill wins over the freshly filled line.
            if (flush_pend_q || flush_i) valid_d = '0;
            flush_pend_d  = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      k_q          <= '0;
      line_q       <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      line_q       <= line_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ack) begin
      data_q[ridx][k_q] <= mem_data_i;
      if (last) tag_q[ridx] <= rtag;
    end
  end

  assign cpu_inst_o  = (!rst && hit) ? data_q[idx][off] : '0;
  assign cpu_stall_o = !rst && (miss || (state_q == StRefill));
  assign mem_req_o   = (state_q == StRefill);
  assign mem_addr_o  = mem_req_o ? {line_q, k_q, 2'b00} : '0;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: fills, hits, eviction, slow memory, flush and reset cases.
// Counter checks are included when ICACHE_PERF_EN is defined.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce;
  logic [31:0] cpu_addr;
  logic [31:0] inst;
  logic        stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int          n_total = 0;
  int          n_bad   = 0;
  int          wait_cycles = 0;
  int          wcnt = 0;
  int          nack;
  logic [31:0] acked [16];
  int          st;
  logic [31:0] got;

  always #5 clk = ~clk;

  inst_cache dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce),
    .cpu_addr_i (cpu_addr),
    .cpu_inst_o (inst),
    .cpu_stall_o(stall),
    .flush_i    (flush),
    .mem_req_o  (mem_req),
    .mem_addr_o (mem_addr),
    .mem_ack_i  (mem_ack),
    .mem_data_i (mem_data)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  // Memory word contents: {~addr[15:0], addr[15:0]}, e.g. 0x104 -> 0xFEFB0104.
  function automatic logic [31:0] fm(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory model: ack after wait_cycles idle request cycles; garbage data off-ack.
  assign mem_ack  = mem_req && (wcnt == wait_cycles);
  assign mem_data = mem_ack ? fm(mem_addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Fetch until the stall clears; returns stall cycle count and the delivered word.
  task automatic fetch(input logic [31:0] a, input int flush_at,
                       output int stalls, output logic [31:0] word);
    bit done = 1'b0;
    stalls   = 0;
    word     = '0;
    nack     = 0;
    cpu_addr = a;
    cpu_ce   = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      flush = (c > 0) && (nack == flush_at);
      @(negedge clk);
      if (!stall) begin
        word = inst;
        done = 1'b1;
      end else begin
        if (c == 0) check_eq("miss_inst_zero", inst, 32'h0);
        stalls++;
        if (mem_req && mem_ack && nack < 16) begin
          acked[nack] = mem_addr;
          nack++;
        end
      end
      @(posedge clk); #1;
    end
    flush  = 1'b0;
    cpu_ce = 1'b0;
    check_eq("fetch_done", 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cpu_ce = 1'b0; cpu_addr = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cpu_ce = 1'b1; cpu_addr = 32'h104;
    @(negedge clk);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_ce = 1'b0;
    @(posedge clk); #1;

    // Cold miss, zero-wait memory.
    fetch(32'h104, -1, st, got);
    check_eq("t1_stalls", 32'(st), 32'd5);
    check_eq("t1_inst", got, 32'hFEFB_0104);
    check_eq("t1_req0", acked[0], 32'h100);
    check_eq("t1_req1", acked[1], 32'h104);
    check_eq("t1_req2", acked[2], 32'h108);
    check_eq("t1_req3", acked[3], 32'h10C);

    // Same-line hits: three more hit cycles.
    fetch(32'h10C, -1, st, got);
    check_eq("t2_hit_stalls", 32'(st), 32'd0);
    check_eq("t2_hit_inst", got, 32'hFEF3_010C);
    check_eq("t2_hit_noreq", 32'(nack), 32'd0);
    fetch(32'h104, -1, st, got);
    fetch(32'h104, -1, st, got);
    check_eq("t2_hit2_inst", got, 32'hFEFB_0104);
`ifdef ICACHE_PERF_EN
    check_eq("cnt_miss", miss_cnt, 32'd1);
    check_eq("cnt_hit", hit_cnt, 32'd4);
`endif
    fetch(32'h110, -1, st, got);
    check_eq("t2_miss_stalls", 32'(st), 32'd5);
    check_eq("t2_miss_req0", acked[0], 32'h110);
    check_eq("t2_miss_req3", acked[3], 32'h11C);
    check_eq("t2_miss_inst", got, 32'hFEEF_0110);

    // Conflict eviction on index 0.
    fetch(32'h000, -1, st, got);
    check_eq("t3_fill0_stalls", 32'(st), 32'd5);
    fetch(32'h100, -1, st, got);
    check_eq("t3_evict_stalls", 32'(st), 32'd5);
    check_eq("t3_evict_inst", got, 32'hFEFF_0100);
    fetch(32'h000, -1, st, got);
    check_eq("t3_refetch_stalls", 32'(st), 32'd5);
    check_eq("t3_refetch_inst", got, 32'hFFFF_0000);

    // Two wait cycles per word.
    wait_cycles = 2;
    fetch(32'h048, -1, st, got);
    check_eq("t4_stalls", 32'(st), 32'd13);
    check_eq("t4_req2", acked[2], 32'h048);
    check_eq("t4_inst", got, 32'hFFB7_0048);
    wait_cycles = 0;

    // Fetch disabled on a cached address.
    cpu_addr = 32'h048; cpu_ce = 1'b0;
    @(negedge clk);
    check_eq("ce0_inst", inst, 32'h0);
    check_eq("ce0_stall", 32'(stall), 32'd0);
    check_eq("ce0_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;

    // Flush during refill: fill completes, then the same address misses again.
    fetch(32'h200, 1, st, got);
    check_eq("t5_refill_flush_stalls", 32'(st), 32'd10);
    check_eq("t5_refill_flush_acks", 32'(nack), 32'd8);
    check_eq("t5_refill_flush_inst", got, 32'hFDFF_0200);

    // Idle flush: same-cycle lookup still hits, afterwards cached lines miss.
    cpu_addr = 32'h200; cpu_ce = 1'b1; flush = 1'b1;
    @(negedge clk);
    check_eq("t5_flush_cycle_stall", 32'(stall), 32'd0);
    check_eq("t5_flush_cycle_inst", inst, 32'hFDFF_0200);
    @(posedge clk); #1;
    flush = 1'b0; cpu_ce = 1'b0;
    fetch(32'h110, -1, st, got);
    check_eq("t5_after_flush_110", 32'(st), 32'd5);
    fetch(32'h200, -1, st, got);
    check_eq("t5_after_flush_200", 32'(st), 32'd5);

    // Reset while word 2 is requested.
    cpu_addr = 32'h300; cpu_ce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_word2_addr", mem_addr, 32'h308);
    check_eq("t6_rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_ce = 1'b0;
    @(negedge clk);
    check_eq("t6_post_rst_req", 32'(mem_req), 32'd0);
    check_eq("t6_post_rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    fetch(32'h200, -1, st, got);
    check_eq("t6_invalid_200", 32'(st), 32'd5);
    fetch(32'h110, -1, st, got);
    check_eq("t6_invalid_110", 32'(st), 32'd5);
`ifdef ICACHE_PERF_EN
    check_eq("cnt_miss_after_rst", miss_cnt, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache between the CPU instruction-fetch port and a slow instruction memory. It answers hits combinationally, in the same cycle the CPU presents the fetch address, like the plain instruction ROM it replaces. On a miss it stalls the CPU and refills a whole line through a one-word-at-a-time req/ack handshake. It sits in the SoC top in place of the direct cpu↔ROM connection, with the ROM moved behind `mem_*`.

## Interface

**Parameters**
- `LINE_WORDS`, 4: 32-bit words per line; power of two, ≥2.
- `NUM_LINES`, 16: number of lines; power of two, ≥2.

**Ports** (clock and reset first)
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_ce_i` in 1: fetch enable.
- `cpu_addr_i` in 32: fetch byte address; bits [1:0] ignored.
- `cpu_inst_o` out 32: fetched instruction (combinational).
- `cpu_stall_o` out 1: stall request to the pipeline (combinational).
- `flush_i` in 1: invalidate all lines (fence.i).
- `mem_req_o` out 1: memory word request.
- `mem_addr_o` out 32: word-aligned address of the requested word.
- `mem_ack_i` in 1: request accepted; `mem_data_i` is valid in this cycle.
- `mem_data_i` in 32: returned word.
- `hit_cnt_o` out 32: hit counter; present only with `ICACHE_PERF_EN`.
- `miss_cnt_o` out 32: miss counter; present only with `ICACHE_PERF_EN`.

## Operation

**Address split**, with W = log2(LINE_WORDS) and L = log2(NUM_LINES):
- word offset = [2+W-1:2]
- index = [2+W+L-1:2+W]
- tag = [31:2+W+L]

**Storage**
- data array: NUM_LINES×LINE_WORDS×32, flops.
- tag array.
- one valid bit per line.

**Hit.** In IDLE, with `cpu_ce_i`=1, valid[index]=1 and tag match:
- `cpu_inst_o` = the addressed word.
- `cpu_stall_o`=0.

**Miss.** In IDLE, with `cpu_ce_i`=1 and no hit:
- `cpu_stall_o`=1 and `cpu_inst_o`=0 in that cycle.
- Next state REFILL with base = `cpu_addr_i` with bits [2+W-1:0] cleared; word counter k=0.

**REFILL**
- `mem_req_o`=1 and `mem_addr_o`=base+4k.
- On a cycle with `mem_ack_i`=1: write `mem_data_i` to word k of the line at index; k←k+1.
- Ack on the last word (k=LINE_WORDS-1): write the tag, set the valid bit, return to IDLE.
- `cpu_stall_o`=1 throughout REFILL.

**Idle outputs**
- `cpu_ce_i`=0 → `cpu_inst_o`=0, `cpu_stall_o`=0, no lookup, no refill.
- In IDLE, `mem_req_o`=0 and `mem_addr_o`=0.

**Flush**
- In IDLE, `flush_i`=1 clears all valid bits at the next edge.
- The lookup in that same cycle still uses the pre-flush valid bits.
- During REFILL, `flush_i` sets a pending flag. The refill runs to completion, then all valid bits are cleared, including the line just filled. The CPU then misses and refetches.

## Timing

**Reset values:** state IDLE, all valid bits 0, k=0, flush-pending 0, `mem_req_o`=0, `mem_addr_o`=0, counters 0. While `rst`=1, `cpu_stall_o`=0 and `cpu_inst_o`=0.

**Hit latency:** 0 cycles (combinational).

**Miss timing**
- Miss detected in cycle T; the first request appears in T+1.
- With zero-wait memory (ack in the same cycle as req), the last ack is in T+LINE_WORDS.
- The line hits in T+LINE_WORDS+1, so stall is high for LINE_WORDS+1 cycles.
- Each memory wait cycle adds one stall cycle.

**Handshake rules**
- `mem_req_o` and `mem_addr_o` hold stable until ack.
- `mem_ack_i` while `mem_req_o`=0 is ignored.
- Back-to-back words are allowed: a new address may appear in the cycle after an ack.

**CPU obligations and edge cases**
- The CPU holds `cpu_addr_i` and `cpu_ce_i` stable while stalled.
- If `cpu_ce_i` drops mid-refill, the refill still completes.
- Reset mid-refill: the next edge returns to IDLE, drops `mem_req_o` and clears all lines. The memory must tolerate the abandoned request.

## Configuration

**`ICACHE_PERF_EN` defined**
- `hit_cnt_o` increments on each IDLE cycle with `cpu_ce_i`=1 and a hit.
- `miss_cnt_o` increments once per IDLE→REFILL transition.
- Both counters wrap modulo 2^32, clear only on `rst`, and are unaffected by flush.

**Not defined:** the counters and both ports are absent. Functional behaviour is identical.

## Test plan

1. **Cold miss, zero-wait memory, defaults.** Fetch 0x104 → requests 0x100, 0x104, 0x108, 0x10C in consecutive cycles; stall high for 5 cycles; then `cpu_inst_o` = word from 0x104, stall 0.
2. **Line hits after fill.** After test 1, fetch 0x10C → same-cycle hit, no `mem_req_o`. Fetch 0x110 → miss with requests 0x110–0x11C.
3. **Conflict eviction.** Fill 0x000, then fetch 0x100 (both index 0) → miss, refill. Fetch 0x000 again → miss again.
4. **Two-cycle ack latency.** Each word holds req/addr for 3 cycles; stall lasts 13 cycles. Data is captured only on ack cycles.
5. **Flush during refill, then IDLE flush.**
   - Pulse `flush_i` at the second word of a refill → refill completes, the same address then misses again.
   - Pulse `flush_i` in IDLE → the next fetch of any cached line misses.
6. **Reset mid-refill, `cpu_ce_i`=0, and counters.**
   - Assert `rst` at word 2 → next cycle `mem_req_o`=0, all lines invalid.
   - `cpu_ce_i`=0 → inst 0, stall 0.
   - With `ICACHE_PERF_EN`, test 1 followed by 3 hit cycles → `miss_cnt_o`=1, `hit_cnt_o`=4 (the miss's final hit cycle counts).
